sram_sram_generic_1r1w: RTL and testbench

SRAM_SRAM_GENERIC_1R1W -- requirements
Module: sram_SRAM_generic_1r1w

---
 rtl/sram_sram_generic_1r1w_pkg.sv | 12 +
 rtl/sram_sram_generic_1r1w_init_fsm.sv | 53 +++++
 rtl/sram_sram_generic_1r1w.sv | 115 +++++++++++
 tb/tb_sram_sram_generic_1r1w.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_sram_generic_1r1w_pkg.sv
// Shared types for the generic 1R1W SRAM: init FSM states and read-during-write modes.
package sram_generic_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } sram_state_e;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

endpackage

// File: rtl/sram_sram_generic_1r1w_init_fsm.sv
// Post-reset zero-fill sequencer: sweeps init_cnt over every entry once, then opens the array.
// Latency: INIT lasts exactly p_num_entries cycles after reset; no backpressure.
module sram_SRAM_init_fsm
    import sram_generic_pkg::*;
#(
    parameter int p_num_entries = 256,
    parameter int p_init_clear  = 1,
    localparam int c_addr_nbits = $clog2(p_num_entries)
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    init_busy,
    output logic                    init_we,
    output logic [c_addr_nbits-1:0] init_cnt,
    output logic                    ready
);

    localparam logic [c_addr_nbits-1:0] c_last  = c_addr_nbits'(p_num_entries - 1);
    localparam logic                    c_clear = (p_init_clear != 0);

    sram_state_e             state_q, state_d;
    logic [c_addr_nbits-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= c_clear ? INIT : READY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == INIT) begin
            if (cnt_q == c_last) begin
                state_d = READY;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + c_addr_nbits'(1);
            end
        end
    end

    // Busy is also raised combinationally while reset is held so it never glitches low.
    assign init_busy = (state_q == INIT) | (reset & c_clear);
    assign init_we   = (state_q == INIT) & ~reset;
    assign ready     = (state_q == READY) & ~reset;
    assign init_cnt  = cnt_q;

endmodule

// File: rtl/sram_sram_generic_1r1w.sv
// Generic one-read/one-write SRAM with byte mask, selectable RDW mode and 1- or 2-cycle read pipeline.
// Latency p_rd_latency; accepts one read and one write every cycle, no backpressure.
module sram_sram_generic_1r1w
    import sram_generic_pkg::*;
#(
    parameter int p_data_nbits  = 32,
    parameter int p_num_entries = 256,
    parameter int p_rd_latency  = 1,
    parameter int p_rdw_mode    = 0,
    parameter int p_init_clear  = 1,
    localparam int c_addr_nbits  = $clog2(p_num_entries),
    localparam int c_data_nbytes = p_data_nbits / 8
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     init_busy,
    input  logic                     wen,
    input  logic [c_data_nbytes-1:0] wmask,
    input  logic [c_addr_nbits-1:0]  waddr,
    input  logic [p_data_nbits-1:0]  wdata,
    input  logic                     ren,
    input  logic [c_addr_nbits-1:0]  raddr,
    output logic [p_data_nbits-1:0]  rdata,
    output logic                     rvalid
);

    localparam logic [c_addr_nbits:0] c_num = (c_addr_nbits + 1)'(p_num_entries);

    logic [p_data_nbits-1:0] mem [p_num_entries];

    logic                    init_we, ready;
    logic [c_addr_nbits-1:0] init_cnt;

    sram_SRAM_init_fsm #(
        .p_num_entries (p_num_entries),
        .p_init_clear  (p_init_clear)
    ) u_init_fsm (
        .clk       (clk),
        .reset     (reset),
        .init_busy (init_busy),
        .init_we   (init_we),
        .init_cnt  (init_cnt),
        .ready     (ready)
    );

    logic wr_in_range, rd_in_range, wr_act, rd_act;

    assign wr_in_range = {1'b0, waddr} < c_num;
    assign rd_in_range = {1'b0, raddr} < c_num;
    assign wr_act      = ready & wen & wr_in_range;
    assign rd_act      = ready & ren;

    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[init_cnt] <= '0;
        end else if (wr_act) begin
            for (int b = 0; b < c_data_nbytes; b++) begin
                if (wmask[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    logic [p_data_nbits-1:0] old_word, merged_word, rd_word;

    assign old_word = rd_in_range ? mem[raddr] : '0;

    always_comb begin
        merged_word = old_word;
        for (int b = 0; b < c_data_nbytes; b++) begin
            if (wmask[b]) merged_word[8*b +: 8] = wdata[8*b +: 8];
        end
    end

    // Write is already qualified by range, so an out-of-range read can never pick the merge.
    assign rd_word = (p_rdw_mode == RDW_NEW && wr_act && waddr == raddr) ? merged_word : old_word;

    logic                    pipe_vld;
    logic [p_data_nbits-1:0] pipe_dat;

    generate
        if (p_rd_latency == 2) begin : g_lat2
            logic                    s1_vld_q;
            logic [p_data_nbits-1:0] s1_dat_q;

            always_ff @(posedge clk) begin
                if (reset) s1_vld_q <= 1'b0;
                else       s1_vld_q <= rd_act;
                if (rd_act) s1_dat_q <= rd_word;
            end

            assign pipe_vld = s1_vld_q;
            assign pipe_dat = s1_dat_q;
        end else begin : g_lat1
            assign pipe_vld = rd_act;
            assign pipe_dat = rd_word;
        end
    endgenerate

    logic                    out_vld_q;
    logic [p_data_nbits-1:0] out_dat_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
        end else begin
            out_vld_q <= pipe_vld;
            if (pipe_vld) out_dat_q <= pipe_dat;
        end
    end

    assign rvalid = out_vld_q & ~reset;
    assign rdata  = reset ? '0 : out_dat_q;

endmodule

// File: tb/tb_sram_sram_generic_1r1w.sv
// Three SRAM configurations share one stimulus stream and are checked against a behavioural model.
module tb_sram_sram_generic_1r1w;

    localparam int NI = 3;
    localparam int P_N   [NI] = '{16, 16, 12};
    localparam int P_LAT [NI] = '{1, 2, 2};
    localparam int P_RDW [NI] = '{0, 1, 0};

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wen = 1'b0;
    logic [3:0]  wmask = 4'h0;
    logic [3:0]  waddr = 4'h0;
    logic [31:0] wdata = 32'h0;
    logic        ren = 1'b0;
    logic [3:0]  raddr = 4'h0;

    logic        busy [NI];
    logic        rv   [NI];
    logic [31:0] rd   [NI];

    always #5 clk = ~clk;

    sram_sram_generic_1r1w #(.p_num_entries(16), .p_rd_latency(1), .p_rdw_mode(0)) u_a (
        .clk(clk), .reset(reset), .init_busy(busy[0]), .wen(wen), .wmask(wmask), .waddr(waddr),
        .wdata(wdata), .ren(ren), .raddr(raddr), .rdata(rd[0]), .rvalid(rv[0]));
    sram_sram_generic_1r1w #(.p_num_entries(16), .p_rd_latency(2), .p_rdw_mode(1)) u_b (
        .clk(clk), .reset(reset), .init_busy(busy[1]), .wen(wen), .wmask(wmask), .waddr(waddr),
        .wdata(wdata), .ren(ren), .raddr(raddr), .rdata(rd[1]), .rvalid(rv[1]));
    sram_sram_generic_1r1w #(.p_num_entries(12), .p_rd_latency(2), .p_rdw_mode(0)) u_c (
        .clk(clk), .reset(reset), .init_busy(busy[2]), .wen(wen), .wmask(wmask), .waddr(waddr),
        .wdata(wdata), .ren(ren), .raddr(raddr), .rdata(rd[2]), .rvalid(rv[2]));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] m);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Behavioural model: array contents, remaining init cycles, and a delay line of read results.
    logic [31:0] m_mem  [NI][16];
    int          m_left [NI];
    bit          m_pv   [NI];
    logic [31:0] m_pd   [NI];
    bit          m_ov   [NI];
    logic [31:0] m_od   [NI];
    bit          started = 1'b0;

    initial begin
        for (int i = 0; i < NI; i++) begin
            m_left[i] = 0; m_pv[i] = 0; m_pd[i] = '0; m_ov[i] = 0; m_od[i] = '0;
            for (int a = 0; a < 16; a++) m_mem[i][a] = '0;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            bit          nv;
            logic [31:0] nd;
            nv = 1'b0;
            nd = '0;
            if (reset) begin
                m_left[i] = P_N[i];
                m_pv[i] = 1'b0;
                m_ov[i] = 1'b0;
                m_od[i] = '0;
            end else begin
                if (m_left[i] > 0) begin
                    m_mem[i][P_N[i] - m_left[i]] = '0;
                    m_left[i]--;
                end else begin
                    if (ren) begin
                        nv = 1'b1;
                        if (int'(raddr) < P_N[i]) begin
                            nd = m_mem[i][raddr];
                            if (P_RDW[i] == 1 && wen && waddr == raddr) nd = merge(nd, wdata, wmask);
                        end
                    end
                    if (wen && int'(waddr) < P_N[i])
                        m_mem[i][waddr] = merge(m_mem[i][waddr], wdata, wmask);
                end
                if (P_LAT[i] == 1) begin
                    m_ov[i] = nv;
                    if (nv) m_od[i] = nd;
                end else begin
                    m_ov[i] = m_pv[i];
                    if (m_pv[i]) m_od[i] = m_pd[i];
                    m_pv[i] = nv;
                    m_pd[i] = nd;
                end
            end
        end
        if (reset) started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("model_busy%0d", i), {31'b0, busy[i]}, {31'b0, (reset || m_left[i] > 0)});
                chk($sformatf("model_rvalid%0d", i), {31'b0, rv[i]}, {31'b0, (!reset && m_ov[i])});
                chk($sformatf("model_rdata%0d", i), rd[i], reset ? 32'h0 : m_od[i]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic count_busy(input int inst, input int exp);
        int n = 0;
        for (int k = 0; k < 40; k++) begin
            if (busy[inst]) n++;
            step();
        end
        chk($sformatf("busy_len%0d", inst), n, exp);
    endtask

    initial begin
        int nvld;
        #2;
        reset = 1'b1;
        step();
        chk("rst_rvalid", {31'b0, rv[0]}, 32'h0);
        chk("rst_rdata", rd[1], 32'h0);
        chk("rst_busy", {31'b0, busy[2]}, 32'h1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        fork
            count_busy(0, 16);
            count_busy(2, 12);
        join

        // zero-fill visible at every address
        for (int a = 0; a < 16; a++) begin
            ren = 1'b1; raddr = 4'(a);
            step();
            chk($sformatf("zf_vld%0d", a), {31'b0, rv[0]}, 32'h1);
            chk($sformatf("zf_dat%0d", a), rd[0], 32'h0);
        end
        ren = 1'b0;
        step();

        // out-of-range on the 12-entry instance
        wen = 1'b1; waddr = 4'd13; wdata = 32'hFFFF_FFFF; wmask = 4'hF;
        step();
        wen = 1'b0; ren = 1'b1; raddr = 4'd13;
        step();
        ren = 1'b0;
        step();
        chk("oor_vld", {31'b0, rv[2]}, 32'h1);
        chk("oor_dat", rd[2], 32'h0);
        for (int a = 0; a < 12; a++) begin
            ren = 1'b1; raddr = 4'(a);
            step();
            ren = 1'b0;
            step();
            chk($sformatf("oor_keep%0d", a), rd[2], 32'h0);
        end

        // masked write
        wen = 1'b1; waddr = 4'd3; wdata = 32'hAABB_CCDD; wmask = 4'hF;
        step();
        wdata = 32'h1122_3344; wmask = 4'b0101;
        step();
        wen = 1'b0; ren = 1'b1; raddr = 4'd3;
        step();
        ren = 1'b0;
        chk("mask_l1", rd[0], 32'hAA22_CC44);
        step();
        chk("mask_l2", rd[2], 32'hAA22_CC44);

        // read-during-write on a zeroed word
        ren = 1'b1; wen = 1'b1; raddr = 4'd5; waddr = 4'd5; wdata = 32'hFFFF_FFFF; wmask = 4'b0011;
        step();
        ren = 1'b0; wen = 1'b0;
        chk("rdw_old", rd[0], 32'h0000_0000);
        step();
        chk("rdw_new", rd[1], 32'h0000_FFFF);

        // latency-2 pipelining with a write behind the second read
        wen = 1'b1; wmask = 4'hF;
        waddr = 4'd0; wdata = 32'h0000_00A0; step();
        waddr = 4'd1; wdata = 32'h0000_00B1; step();
        waddr = 4'd2; wdata = 32'h0000_00C2; step();
        wen = 1'b0; ren = 1'b1; raddr = 4'd0;
        step();
        chk("pipe_t1_vld", {31'b0, rv[2]}, 32'h0);
        raddr = 4'd1; wen = 1'b1; waddr = 4'd1; wdata = 32'hDEAD_BEEF;
        step();
        wen = 1'b0; raddr = 4'd2;
        chk("pipe_t2_vld", {31'b0, rv[2]}, 32'h1);
        chk("pipe_t2_dat", rd[2], 32'h0000_00A0);
        step();
        ren = 1'b0;
        chk("pipe_t3_dat", rd[2], 32'h0000_00B1);
        step();
        chk("pipe_t4_dat", rd[2], 32'h0000_00C2);
        step();
        chk("pipe_t5_vld", {31'b0, rv[2]}, 32'h0);

        // reset at INIT count 7
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 0; k < 7; k++) step();
        chk("mid_init_busy", {31'b0, busy[0]}, 32'h1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        count_busy(0, 16);

        // reset with two reads in flight on the latency-2 instances
        ren = 1'b1; raddr = 4'd3;
        step();
        raddr = 4'd4;
        step();
        ren = 1'b0; reset = 1'b1;
        #1;
        chk("flight_vld_b", {31'b0, rv[1]}, 32'h0);
        chk("flight_vld_c", {31'b0, rv[2]}, 32'h0);
        step();
        reset = 1'b0;
        nvld = 0;
        for (int k = 0; k < 20; k++) begin
            if (rv[1] || rv[2]) nvld++;
            step();
        end
        chk("flight_dropped", nvld, 0);

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            reset = ($urandom_range(0, 299) == 0);
            ren   = 1'($urandom_range(0, 1));
            wen   = 1'($urandom_range(0, 1));
            waddr = 4'($urandom_range(0, 15));
            raddr = ($urandom_range(0, 3) == 0) ? waddr : 4'($urandom_range(0, 15));
            wdata = $urandom;
            wmask = 4'($urandom_range(0, 15));
            step();
        end
        reset = 1'b0; ren = 1'b0; wen = 1'b0;
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
